// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, memory-stall and halt control for a 5-stage pipeline
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        if_id_uses_rt,
  input  logic        branch_taken,
  input  logic        mem_access,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic [15:0] stall_count,
  output logic        halted,
  output logic        mem_error
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {RUN, MEM_WAIT, DRAIN, HALTED, ERROR} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] drain_cnt;

  logic load_use;
  logic freeze;
  logic as_run;

  assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs) || (if_id_uses_rt && (id_ex_rd == if_id_rt)));

  // MEM_WAIT keeps freezing until mem_ready, whatever mem_access says.
  assign freeze = (((state == RUN) || (state == DRAIN)) && mem_access && !mem_ready) ||
                  ((state == MEM_WAIT) && !mem_ready);
  assign as_run = (state == RUN) || ((state == MEM_WAIT) && mem_ready);

  assign halted    = !reset && (state == HALTED);
  assign mem_error = !reset && (state == ERROR);

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      mem_wb_flush = 1'b1;
    end else if (as_run) begin
      if (branch_taken) begin
        pc_write     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
      end else if (load_use) begin
        id_ex_flush  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
      end
    end else if (state == DRAIN) begin
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      stall_count <= 16'd0;
    end else begin
      if (((state == RUN) || (state == MEM_WAIT)) && !pc_write && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end else if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready)
            state <= RUN;
          else if (wait_cnt == WAIT_MAX)
            state <= ERROR;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        DRAIN: begin
          if (!freeze) begin
            if (drain_cnt == DRAIN_MAX)
              state <= HALTED;
            else
              drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rd, if_id_rs, if_id_rt;
  logic        if_id_uses_rt, branch_taken, mem_access, mem_ready, halt_req;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [15:0] stall_count;
  logic        halted, mem_error;

  pipeline_ctrl #(.MEM_TIMEOUT(3), .DRAIN_CYCLES(3)) dut (
    .clock(clock), .reset(reset),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .mem_access(mem_access), .mem_ready(mem_ready),
    .halt_req(halt_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .stall_count(stall_count), .halted(halted), .mem_error(mem_error)
  );

  always #5 clock = ~clock;

  // {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_f, id_ex_f, ex_mem_f, mem_wb_f}
  localparam logic [8:0] RUNV = 9'b1_1111_0000;
  localparam logic [8:0] FRZ  = 9'b0_0000_0001;
  localparam logic [8:0] BR   = 9'b1_0011_1100;
  localparam logic [8:0] LU   = 9'b0_0011_0100;
  localparam logic [8:0] DR   = 9'b0_0111_1000;
  localparam logic [8:0] OFF  = 9'b0_0000_0000;
  localparam logic [8:0] RST  = 9'b0_0000_1111;

  typedef struct {
    logic [8:0]  ctl;
    logic [15:0] sc;
    logic        h;
    logic        e;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t x;
      logic [8:0] got;
      x   = sb.pop_front();
      got = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
      n_checks++;
      if (got !== x.ctl || stall_count !== x.sc || halted !== x.h || mem_error !== x.e) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b sc=%0d halted=%b err=%b, expected ctl=%b sc=%0d halted=%b err=%b",
                 x.name, got, stall_count, halted, mem_error, x.ctl, x.sc, x.h, x.e);
      end
    end
  end

  task automatic drive(input logic rst, input logic ld, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic br, input logic ma,
                       input logic mr, input logic hl);
    @(posedge clock);
    #1;
    reset = rst; id_ex_memread = ld; id_ex_rd = rd; if_id_rs = rs; if_id_rt = rt;
    if_id_uses_rt = urt; branch_taken = br; mem_access = ma; mem_ready = mr; halt_req = hl;
  endtask

  task automatic step(input logic rst, input logic ld, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic br, input logic ma,
                      input logic mr, input logic hl, input logic [8:0] ctl, input logic [15:0] sc,
                      input logic h, input logic e, input string name);
    exp_t x;
    drive(rst, ld, rd, rs, rt, urt, br, ma, mr, hl);
    x.ctl = ctl; x.sc = sc; x.h = h; x.e = e; x.name = name;
    sb.push_back(x);
  endtask

  initial begin
    reset = 1'b1; id_ex_memread = 0; id_ex_rd = 0; if_id_rs = 0; if_id_rt = 0;
    if_id_uses_rt = 0; branch_taken = 0; mem_access = 0; mem_ready = 0; halt_req = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //   rst ld rd rs rt urt br ma mr hl  ctl   sc  h  e
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, 0, "reset_state");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 0, 0, 0, "run_idle");
    step(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, LU,   0, 0, 0, "load_use_rs");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 1, 0, 0, "stall_count_1");
    step(0, 1, 7, 3, 7, 1, 0, 0, 0, 0, LU,   1, 0, 0, "load_use_rt");
    step(0, 1, 7, 3, 7, 0, 0, 0, 0, 0, RUNV, 2, 0, 0, "rt_unused_no_stall");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 2, 0, 0, "rd_zero_no_stall");
    step(0, 1, 5, 5, 0, 0, 1, 0, 0, 0, BR,   2, 0, 0, "branch_over_load_use");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 2, 0, 0, "branch_no_stall");
    // memory freeze: 4 cycles low then ready
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,  2, 0, 0, "reset_hold_count");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  0, 0, 0, "freeze_1");
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, FRZ,  1, 0, 0, "freeze_2_over_branch");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ,  2, 0, 0, "freeze_3_wait");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  3, 0, 0, "freeze_4");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, RUNV, 4, 0, 0, "mem_ready_run");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 4, 0, 0, "after_freeze_count4");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  4, 0, 0, "freeze_then_lu");
    step(0, 1, 9, 9, 0, 0, 0, 1, 1, 0, LU,   5, 0, 0, "mem_wait_ready_lu");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 6, 0, 0, "lu_counted");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,  6, 0, 0, "halt_during_freeze");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, RUNV, 7, 0, 0, "halt_ignored_1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 7, 0, 0, "halt_ignored_2");
    // halt with freeze during drain
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUNV, 7, 0, 0, "halt_req");
    step(0, 1, 5, 5, 0, 0, 1, 0, 0, 0, DR,   7, 0, 0, "drain_1_ignores_br");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  7, 0, 0, "drain_freeze_1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  7, 0, 0, "drain_freeze_2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DR,   7, 0, 0, "drain_2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DR,   7, 0, 0, "drain_3");
    step(0, 1, 5, 5, 0, 0, 1, 1, 0, 1, OFF,  7, 1, 0, "halted");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF,  7, 1, 0, "halted_stays");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,  7, 0, 0, "reset_from_halted");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 0, 0, 0, "run_after_halt");
    // reset mid-drain
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RUNV, 0, 0, 0, "halt_req_2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DR,   0, 0, 0, "drain_before_reset");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, 0, "reset_mid_drain");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 0, 0, 0, "run_after_drain_reset_1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 0, 0, 0, "run_after_drain_reset_2");
    // timeout into ERROR
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  0, 0, 0, "to_freeze_run");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  1, 0, 0, "to_wait_1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  2, 0, 0, "to_wait_2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  3, 0, 0, "to_wait_3");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  4, 0, 0, "to_wait_4");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, OFF,  5, 0, 1, "error");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OFF,  5, 0, 1, "error_stays");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,  5, 0, 0, "reset_from_error");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 0, 0, 0, "run_after_error");
    // saturation: 65535 unchecked stalls, then one more
    for (int i = 0; i < 65535; i++) drive(0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, LU,   16'hFFFF, 0, 0, "saturate_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV, 16'hFFFF, 0, 0, "saturated");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
